// File: rtl/mem_rsp_collector_pkg.sv
// -----------------------------------------------------------------------------
// mem_rsp_pkg
// Shared constants and types for the memory read-response collector.
//   MEM_DATA_WIDTH : word width of the 16x32 memory read port
//   RSP_FIFO_DEPTH : default number of buffered response words
//   RSP_DROP_WIDTH : default width of the dropped-word counter
//   fifo_op_e      : per-cycle FIFO operation, encoded as {push, pop}
// -----------------------------------------------------------------------------
package mem_rsp_pkg;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int RSP_FIFO_DEPTH = 8;
    localparam int RSP_DROP_WIDTH = 8;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage : mem_rsp_pkg

// File: rtl/mem_rsp_collector_fifo.sv
// -----------------------------------------------------------------------------
// mem_rsp_fifo
// Synchronous single-clock FIFO that buffers memory read words for the
// collector. The caller only issues a push when a slot is available (or a pop
// frees one in the same cycle) and only issues a pop when the FIFO is non-empty.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   push      : write wr_data at the write pointer
//   pop       : advance the read pointer
//   wr_data   : word to store
//   rd_data   : word at the read pointer (combinational mux of storage)
//   full      : registered, count == FIFO_DEPTH
//   empty     : registered, count == 0
//   count     : registered occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module mem_rsp_fifo
    import mem_rsp_pkg::*;
#(
    parameter  int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter  int FIFO_DEPTH = RSP_FIFO_DEPTH,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_nxt;
    fifo_op_e              op;

    // NOTE: storage is deliberately left out of reset; validity is tracked by
    // count, so resetting the array would only cost reset fan-out. The write
    // uses <= like all clocked state so same-edge readers see the old value.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

    // NOTE: count_nxt gets a default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        count_nxt = count;
        op        = fifo_op_e'({push, pop});
        unique case (op)
            FIFO_PUSH: count_nxt = count + 1'b1;
            FIFO_POP:  count_nxt = count - 1'b1;
            default:   count_nxt = count;
        endcase
    end

    // Pointers are exactly PTR_W bits, so they wrap from FIFO_DEPTH-1 to 0
    // without explicit compare logic (FIFO_DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            // Flags are registered from the next count so they need no
            // decode logic after the clock edge.
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
        end
    end

endmodule : mem_rsp_fifo

// File: rtl/mem_rsp_collector.sv
// -----------------------------------------------------------------------------
// mem_rsp_collector
// Captures every word the memory presents with valid_out, buffers it in a
// small FIFO and offers it to a consumer over valid/ready. The memory cannot
// be stalled, so words arriving while the buffer is full are dropped, flagged
// and counted. A running XOR checksum covers all accepted words.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset (highest prio)
//   in_data   : memory Data_out
//   in_valid  : memory valid_out, one word per high cycle
//   clr       : clears overflow, drop_cnt and checksum (FIFO untouched)
//   m_data    : head-of-FIFO word
//   m_valid   : head word is valid
//   m_ready   : consumer takes the head word
//   count     : FIFO occupancy, 0..FIFO_DEPTH
//   overflow  : sticky flag, set by any drop
//   drop_cnt  : saturating count of dropped words
//   checksum  : XOR of accepted words since reset or clr
// -----------------------------------------------------------------------------
module mem_rsp_collector
    import mem_rsp_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int FIFO_DEPTH = RSP_FIFO_DEPTH,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    parameter int DROP_WIDTH = RSP_DROP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic [DROP_WIDTH-1:0] drop_cnt,
    output logic [DATA_WIDTH-1:0] checksum
);

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic accept;
    logic drop;

    // A full FIFO still accepts when the head leaves in the same cycle, which
    // sustains one push and one pop per cycle at full occupancy.
    assign m_valid = ~fifo_empty;
    assign pop     = m_valid & m_ready;
    assign accept  = in_valid & (~fifo_full | pop);
    assign drop    = in_valid & ~accept;

    mem_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (m_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // clr restarts the checksum; a word accepted in the clr cycle becomes the
    // new starting value rather than being lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (clr) begin
            checksum <= accept ? in_data : '0;
        end else if (accept) begin
            checksum <= checksum ^ in_data;
        end
    end

    // A drop coinciding with clr is counted after the clear, so the event is
    // never lost: overflow stays 1 and drop_cnt restarts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            overflow <= drop;
            drop_cnt <= {{(DROP_WIDTH-1){1'b0}}, drop};
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule : mem_rsp_collector

// File: doc/mem_rsp_collector.md
# mem_rsp_collector

Downstream stage of the 16×32 memory block: captures every read word the memory presents on `Data_out` when `valid_out` is high, buffers it in a small FIFO and hands it to the consumer over a valid/ready handshake. The memory has no backpressure, so words that arrive while the buffer is full are dropped and counted. The block also keeps a running XOR checksum of accepted words for end-of-test scoreboarding.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; matches the memory data width.
- `FIFO_DEPTH`, 8: buffer entries; power of two, ≥2.
- `CNT_WIDTH`, `$clog2(FIFO_DEPTH)+1`: width of the occupancy count.
- `DROP_WIDTH`, 8: width of the drop counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in DATA_WIDTH: connected to memory `Data_out`.
- `in_valid` in 1: connected to memory `valid_out`; one word per high cycle.
- `clr` in 1: synchronous clear of `overflow`, `drop_cnt` and `checksum`. FIFO contents are unaffected.
- `m_data` out DATA_WIDTH: head-of-FIFO word.
- `m_valid` out 1: head word is valid.
- `m_ready` in 1: consumer accepts the head word.
- `count` out CNT_WIDTH: current occupancy, 0..FIFO_DEPTH.
- `overflow` out 1: sticky; set by any drop.
- `drop_cnt` out DROP_WIDTH: dropped words, saturating at all-ones.
- `checksum` out DATA_WIDTH: XOR of all accepted words since reset or `clr`.

## Operation
- Push: an attempt occurs when `in_valid`=1. The word is accepted if `count`<FIFO_DEPTH, or if `count`=FIFO_DEPTH and a pop occurs in the same cycle. Otherwise the word is dropped.
- Pop: occurs when `m_valid`=1 and `m_ready`=1. The read pointer advances.
- `m_valid` = (`count`≠0). `m_data` = storage[rd_ptr]; its value is don't-care when `m_valid`=0.
- `count` next value: +1 on push only, −1 on pop only, unchanged on push+pop or on a drop.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally from FIFO_DEPTH−1 to 0.
- Accepted push: `checksum` ← `checksum` ^ `in_data`. Dropped words do not affect `checksum`.
- Drop: `overflow` ← 1; `drop_cnt` ← `drop_cnt`+1, saturating.
- `clr`:
  - Sets `overflow`=0 and `drop_cnt`=0.
  - Sets `checksum` = accepted word in the same cycle, else 0.
  - A drop in the same cycle as `clr` leaves `overflow`=1 and `drop_cnt`=1.
- `m_ready` while `m_valid`=0 has no effect.
- `m_data` must stay stable while `m_valid`=1 and `m_ready`=0.

## Timing
- Reset values: `count`=0, `m_valid`=0, `overflow`=0, `drop_cnt`=0, `checksum`=0, pointers=0. `m_data` is don't-care.
- `rst` takes priority over all inputs. Reset mid-stream discards buffered words; an `in_valid` in the reset cycle is ignored.
- Latency: a word pushed in cycle N is visible on `m_data` with `m_valid`=1 in cycle N+1 if the FIFO was empty. There is no bypass.
- Throughput: one push and one pop per cycle, sustained.
- All outputs are register-driven, except `m_data`, which is a mux of registered storage.

## Structure
- Package `mem_rsp_pkg`: default constants `MEM_DATA_WIDTH`=32, `RSP_FIFO_DEPTH`=8, `RSP_DROP_WIDTH`=8.
- Sub-module `mem_rsp_fifo`:
  - Contains the storage array, pointers and count.
  - Has push/pop/full/empty ports.
  - Takes parameters DATA_WIDTH and FIFO_DEPTH.
- The top level holds accept/drop logic, the checksum and the drop counter.

## Test plan
- Single word: push 0xDEADBEEF with `m_ready`=0.
  - Next cycle: `m_valid`=1, `m_data`=0xDEADBEEF, `count`=1, `checksum`=0xDEADBEEF.
  - Then `m_ready`=1 for one cycle → `count`=0, `m_valid`=0.
- Fill and overflow: push 10 words 0x1..0xA with `m_ready`=0.
  - Result: `count`=8, `overflow`=1, `drop_cnt`=2, `checksum`=0x1^…^0x8=0x8.
  - Drain yields 0x1..0x8 in order.
- Full with simultaneous push and pop: FIFO full, `in_valid`=1 and `m_ready`=1 for 4 cycles.
  - No drops; `count` stays 8.
  - Popped order continues correctly across pointer wrap.
- Clear: after the overflow case, assert `clr` together with a drop.
  - Result: `overflow`=1, `drop_cnt`=1, `checksum`=0.
  - Then assert `clr` alone → `overflow`=0, `drop_cnt`=0.
- Reset mid-stream: reset with 5 buffered words and `in_valid`=1.
  - Next cycle: `count`=0, `m_valid`=0, `checksum`=0.
  - Subsequent push 0x55 → 0x55 is the first word out.
- Saturation: 300 drops with `m_ready`=0 → `drop_cnt`=255.
